indication_word_serializer: RTL and testbench

//  Downstream stage of the echo indication output path. Consumes indication messages
//  {tag, meth, v} from the pipe enq method into a small FIFO, then emits each one as a

---
 rtl/indication_ser_pkg.sv | 35 +++
 rtl/indication_fifo.sv | 65 ++++++
 rtl/indication_word_serializer.sv | 119 +++++++++++
 tb/tb_indication_word_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/indication_ser_pkg.sv
// Shared types and constants for the indication word serializer.
// Build option: INDICATION_CHECKSUM_EN appends a checksum word to every message.
package indication_ser_pkg;

  localparam int MSG_W    = 80;
  localparam int WORD_W   = 32;
  localparam int LEN_BASE = 2;

`ifdef INDICATION_CHECKSUM_EN
  localparam int LEN_WORDS = LEN_BASE + 1;
`else
  localparam int LEN_WORDS = LEN_BASE;
`endif

  typedef struct packed {
    logic [15:0]       tag;
    logic [WORD_W-1:0] meth;
    logic [WORD_W-1:0] v;
  } msg_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_METH = 3'd2,
    ST_VAL  = 3'd3,
    ST_CSUM = 3'd4
  } ser_state_t;

  function automatic logic [WORD_W-1:0] csum_word(input logic [WORD_W-1:0] hdr,
                                                   input logic [WORD_W-1:0] meth,
                                                   input logic [WORD_W-1:0] v);
    return hdr ^ meth ^ v;
  endfunction

endpackage

// File: rtl/indication_fifo.sv
// Registered message FIFO; pointers wrap naturally because DEPTH is a power of two.
module indication_fifo
  import indication_ser_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = msg_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       wr_data_i,
  output T                       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/indication_word_serializer.sv
// Queues indication messages and streams each as header/meth/v[/checksum] words.
// Build options: INDICATION_CHECKSUM_EN (checksum word), INDICATION_ENQ_ASSERT (drop check).
module indication_word_serializer
  import indication_ser_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enq__ENA,
  output logic              enq__RDY,
  input  logic [MSG_W-1:0]  enq_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ser_state_t        state_q, state_d;
  msg_t              head_s;
  logic              full_s, empty_s;
  logic [CW-1:0]     count_s;
  logic              rdy_en_q;
  logic              push_s, hs_s, pop_s, more_s;
  logic [WORD_W-1:0] hdr_s;

  // enq__RDY stays low until the first clock after reset release
  assign enq__RDY  = rdy_en_q && !full_s;
  assign push_s    = enq__ENA && enq__RDY;
  assign out_valid = (state_q != ST_IDLE);
  assign hs_s      = out_valid && out_ready;
  assign pop_s     = hs_s && out_last;
  assign more_s    = (count_s > CW'(1)) || push_s;
  assign hdr_s     = WORD_W'({head_s.tag[TAG_W-1:0], 16'(LEN_WORDS)});

  indication_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (msg_t)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .wr_data_i (msg_t'(enq_v)),
    .rd_data_o (head_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .count_o   (count_s)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s || push_s) state_d = ST_HDR;
        else                    state_d = ST_IDLE;
      end
      ST_HDR: begin
        out_data = hdr_s;
        if (hs_s) state_d = ST_METH;
        else      state_d = ST_HDR;
      end
      ST_METH: begin
        out_data = head_s.meth;
        if (hs_s) state_d = ST_VAL;
        else      state_d = ST_METH;
      end
`ifdef INDICATION_CHECKSUM_EN
      ST_VAL: begin
        out_data = head_s.v;
        if (hs_s) state_d = ST_CSUM;
        else      state_d = ST_VAL;
      end
      ST_CSUM: begin
        out_data = csum_word(hdr_s, head_s.meth, head_s.v);
        out_last = 1'b1;
        if (hs_s) state_d = more_s ? ST_HDR : ST_IDLE;
        else      state_d = ST_CSUM;
      end
`else
      ST_VAL: begin
        out_data = head_s.v;
        out_last = 1'b1;
        if (hs_s) state_d = more_s ? ST_HDR : ST_IDLE;
        else      state_d = ST_VAL;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef INDICATION_ENQ_ASSERT
  // An enqueue offered while full is dropped by design; flag it for integration runs
  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (!(enq__ENA && !enq__RDY))
        else $error("enq__ENA asserted while enq__RDY low: message dropped");
    end
  end
`endif

endmodule

// File: tb/tb_indication_word_serializer.sv
// Self-checking bench: constant vectors, directed corner sequences and a queue-based random model.
module tb_indication_word_serializer;

`ifdef INDICATION_CHECKSUM_EN
  localparam int LEN = 3;
`else
  localparam int LEN = 2;
`endif
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        enq_ena = 1'b0;
  logic        enq_rdy;
  logic [79:0] enq_v = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;

  int checks = 0;
  int failures = 0;

  logic [79:0] mq[$];
  int          midx = 0;
  bit          mrel = 1'b0;

  typedef struct {
    logic [15:0] tag;
    logic [31:0] meth;
    logic [31:0] v;
    logic [31:0] hdr_plain;
    logic [31:0] hdr_cs;
    logic [31:0] csum;
  } vec_t;

  vec_t vecs[4];

  indication_word_serializer #(.FIFO_DEPTH(DEPTH), .TAG_W(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .enq__ENA  (enq_ena),
    .enq__RDY  (enq_rdy),
    .enq_v     (enq_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mword(input logic [79:0] m, input int i);
    logic [31:0] h;
    h = {m[79:64], 16'(LEN)};
    case (i)
      0:       return h;
      1:       return m[63:32];
      2:       return m[31:0];
      default: return h ^ m[63:32] ^ m[31:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT sampled at that edge.
  task automatic cycle();
    bit push, hs, rst_hi;
    rst_hi = nRST;
    push = enq_ena && mrel && (mq.size() < DEPTH);
    hs = out_ready && (mq.size() > 0);
    @(posedge CLK);
    #1;
    if (hs) begin
      if (midx == LEN) begin
        void'(mq.pop_front());
        midx = 0;
      end else begin
        midx++;
      end
    end
    if (push) mq.push_back(enq_v);
    if (rst_hi) mrel = 1'b1;
  endtask

  task automatic model_check(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({name, "_rdy"}, 32'(enq_rdy), 32'(mrel && (mq.size() < DEPTH)));
    if (mq.size() > 0) begin
      chk({name, "_data"}, out_data, mword(mq[0], midx));
      chk({name, "_last"}, 32'(out_last), 32'(midx == LEN));
    end else begin
      chk({name, "_last_idle"}, 32'(out_last), 32'd0);
    end
  endtask

  // Reset asserted right now (mid-cycle), released on the next falling edge.
  task automatic reset_now(input string name);
    #1;
    nRST = 1'b0;
    enq_ena = 1'b0;
    out_ready = 1'b0;
    #1;
    mq.delete();
    midx = 0;
    mrel = 1'b0;
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_data"}, out_data, 32'd0);
    chk({name, "_last"}, 32'(out_last), 32'd0);
    chk({name, "_rdy"}, 32'(enq_rdy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    cycle();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12; i++) begin
      model_check(name);
      cycle();
    end
  endtask

  initial begin
    logic [79:0] a, b, c;
    logic [31:0] exp_w;

    vecs[0] = '{16'h0001, 32'h0000_0005, 32'h0000_1234, 32'h0001_0002, 32'h0001_0003, 32'h0001_1232};
    vecs[1] = '{16'h0001, 32'h0000_0005, 32'h0000_0003, 32'h0001_0002, 32'h0001_0003, 32'h0001_0005};
    vecs[2] = '{16'hFFFF, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_0002, 32'hFFFF_0003, 32'h2152_BEEC};
    vecs[3] = '{16'hA5A5, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_0002, 32'hA5A5_0003, 32'h5A5A_FFFC};

    @(posedge CLK);
    reset_now("reset");
    chk("rdy_after_release", 32'(enq_rdy), 32'd1);

    // Constant vectors: one message into an empty FIFO, host always ready
    for (int k = 0; k < 4; k++) begin
      enq_v = {vecs[k].tag, vecs[k].meth, vecs[k].v};
      enq_ena = 1'b1;
      out_ready = 1'b1;
      cycle();
      enq_ena = 1'b0;
      for (int w = 0; w <= LEN; w++) begin
        case (w)
`ifdef INDICATION_CHECKSUM_EN
          0:       exp_w = vecs[k].hdr_cs;
`else
          0:       exp_w = vecs[k].hdr_plain;
`endif
          1:       exp_w = vecs[k].meth;
          2:       exp_w = vecs[k].v;
          default: exp_w = vecs[k].csum;
        endcase
        chk($sformatf("vec%0d_w%0d_valid", k, w), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_w%0d_data", k, w), out_data, exp_w);
        chk($sformatf("vec%0d_w%0d_last", k, w), 32'(out_last), 32'(w == LEN));
        cycle();
      end
      chk($sformatf("vec%0d_idle", k), 32'(out_valid), 32'd0);
    end

    // Back-to-back messages: no idle cycle between them
    a = {16'h0011, 32'h1111_1111, 32'h2222_2222};
    b = {16'h0022, 32'h3333_3333, 32'h4444_4444};
    enq_v = a;
    enq_ena = 1'b1;
    out_ready = 1'b1;
    cycle();
    enq_v = b;
    for (int i = 0; i < 2 * (LEN + 1); i++) begin
      chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      model_check("b2b");
      cycle();
      enq_ena = 1'b0;
    end
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Stall during the METH word
    a = {16'h0033, 32'hCAFE_F00D, 32'h0BAD_BEEF};
    enq_v = a;
    enq_ena = 1'b1;
    out_ready = 1'b1;
    cycle();
    enq_ena = 1'b0;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, 32'hCAFE_F00D);
      chk("stall_last", 32'(out_last), 32'd0);
      cycle();
    end
    out_ready = 1'b1;
    drain("stall_drain");

    // Fill the FIFO, offer a third message, confirm it was dropped
    a = {16'h0101, 32'hAAAA_0001, 32'hAAAA_0002};
    b = {16'h0202, 32'hBBBB_0001, 32'hBBBB_0002};
    c = {16'h0303, 32'hCCCC_0001, 32'hCCCC_0002};
    out_ready = 1'b0;
    enq_v = a;
    enq_ena = 1'b1;
    cycle();
    enq_v = b;
    cycle();
    chk("full_rdy", 32'(enq_rdy), 32'd0);
    enq_v = c;
    cycle();
    enq_ena = 1'b0;
    chk("full_rdy_held", 32'(enq_rdy), 32'd0);
    chk("full_head", out_data, mword(a, 0));
    out_ready = 1'b1;
    for (int w = 0; w <= LEN; w++) begin
      chk($sformatf("full_a_w%0d", w), out_data, mword(a, w));
      cycle();
    end
    for (int w = 0; w <= LEN; w++) begin
      chk($sformatf("full_b_w%0d", w), out_data, mword(b, w));
      cycle();
    end
    chk("full_idle_after_two", 32'(out_valid), 32'd0);

    // Reset pulse while the VAL word is on the bus
    a = {16'h0404, 32'hDDDD_0001, 32'hDDDD_0002};
    enq_v = a;
    enq_ena = 1'b1;
    out_ready = 1'b1;
    cycle();
    enq_v = {16'h0505, 32'hEEEE_0001, 32'hEEEE_0002};
    cycle();
    enq_ena = 1'b0;
    cycle();
    chk("midrst_val_word", out_data, 32'hDDDD_0002);
    reset_now("midrst");
    chk("midrst_empty", 32'(out_valid), 32'd0);
    a = {16'h0606, 32'hF0F0_0001, 32'hF0F0_0002};
    enq_v = a;
    enq_ena = 1'b1;
    out_ready = 1'b1;
    cycle();
    enq_ena = 1'b0;
    chk("midrst_next_hdr", out_data, mword(a, 0));
    drain("midrst_drain");

    // Random traffic against the queue model
    for (int i = 0; i < 800; i++) begin
      model_check("rand");
      enq_ena = 1'($urandom_range(0, 1));
      enq_v = {16'($urandom), $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    enq_ena = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
